ramen_order_arbiter: RTL and testbench

- Shares one `Ramen` kitchen between `N_KIOSK` ordering kiosks.
- Opens and closes the kitchen's selling session.
- Grants kiosk requests round-robin, serialises each grant into the kitchen's two-cycle order protocol, and routes the order result back to the kiosk that placed it.
- Captures the kitchen's end-of-session totals.

---
 rtl/ramen_pkg.sv | 24 ++
 rtl/rr_arbiter4.sv | 24 ++
 rtl/ramen_order_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_ramen_order_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ramen_pkg.sv
// Shared types for the ramen kitchen front end: ramen flavours, arbiter FSM states
// and the widths of the kitchen's end-of-session report.
package ramen_pkg;

    typedef enum logic [1:0] {
        TONKOTSU     = 2'd0,
        TONKOTSU_SOY = 2'd1,
        MISO         = 2'd2,
        MISO_SOY     = 2'd3
    } ramen_type_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPEN     = 3'd1,
        ISSUE0   = 3'd2,
        ISSUE1   = 3'd3,
        WAIT     = 3'd4,
        TOT_WAIT = 3'd5
    } arb_state_e;

    localparam int SOLD_W = 28;
    localparam int GAIN_W = 15;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: returns the first asserted request at or after ptr.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] gnt_id
);

    logic [1:0] idx;

    always_comb begin
        any    = |req;
        gnt_id = ptr;
        idx    = '0;
        // Scan from the farthest offset down so the closest requester wins last.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/ramen_order_arbiter.sv
// Shares one ramen kitchen between four kiosks: session open/close, round-robin grants,
// two-beat order issue, result routing back to the kiosk and end-of-session totals.
module ramen_order_arbiter
    import ramen_pkg::*;
#(
    parameter int N_KIOSK  = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 session_start,
    input  logic                 session_end,
    input  logic [N_KIOSK-1:0]   req_valid,
    input  logic [2*N_KIOSK-1:0] req_type,
    input  logic [N_KIOSK-1:0]   req_portion,
    output logic [N_KIOSK-1:0]   req_ready,
    output logic                 resp_valid,
    output logic                 resp_success,
    output logic [1:0]           resp_id,
    output logic                 tot_valid,
    output logic [SOLD_W-1:0]    tot_sold,
    output logic [GAIN_W-1:0]    tot_gain,
    output logic [7:0]           reject_cnt,
    output logic                 err,
    output logic                 k_selling,
    output logic                 k_in_valid,
    output logic                 k_portion,
    output logic [1:0]           k_ramen_type,
    input  logic                 k_out_valid_order,
    input  logic                 k_success,
    input  logic                 k_out_valid_tot,
    input  logic [SOLD_W-1:0]    k_sold_num,
    input  logic [GAIN_W-1:0]    k_total_gain
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    arb_state_e         state, state_nxt;
    logic               close_pend, close_nxt;
    logic               final_ord, final_nxt;
    logic [1:0]         rr_ptr, ptr_nxt;
    logic [CNT_W-1:0]   wait_cnt, cnt_nxt;
    ramen_type_e        lat_type;
    logic               lat_portion;
    logic [1:0]         lat_id;

    logic [N_KIOSK-1:0] req_ready_nxt;
    logic               resp_valid_nxt, resp_success_nxt;
    logic [1:0]         resp_id_nxt;
    logic               tot_valid_nxt;
    logic [SOLD_W-1:0]  tot_sold_nxt;
    logic [GAIN_W-1:0]  tot_gain_nxt;
    logic [7:0]         reject_nxt;
    logic               err_nxt, selling_nxt, in_valid_nxt, portion_nxt;
    logic [1:0]         type_nxt;

    logic               any_req, grant_now, close_req;
    logic [1:0]         gnt_id;

    rr_arbiter4 u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .any    (any_req),
        .gnt_id (gnt_id)
    );

    assign grant_now = (state == OPEN) && any_req;
    assign close_req = close_pend | session_end;

    always_comb begin
        state_nxt        = state;
        close_nxt        = close_pend;
        final_nxt        = final_ord;
        ptr_nxt          = rr_ptr;
        cnt_nxt          = wait_cnt;
        req_ready_nxt    = '0;
        resp_valid_nxt   = 1'b0;
        resp_success_nxt = resp_success;
        resp_id_nxt      = resp_id;
        tot_valid_nxt    = 1'b0;
        tot_sold_nxt     = tot_sold;
        tot_gain_nxt     = tot_gain;
        reject_nxt       = reject_cnt;
        err_nxt          = err;
        selling_nxt      = k_selling;
        in_valid_nxt     = 1'b0;
        portion_nxt      = k_portion;
        type_nxt         = k_ramen_type;

        if (state != IDLE && session_end) begin
            close_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (session_start) begin
                    state_nxt   = OPEN;
                    selling_nxt = 1'b1;
                    reject_nxt  = '0;
                    err_nxt     = 1'b0;
                    close_nxt   = 1'b0;
                    final_nxt   = 1'b0;
                end
            end
            OPEN: begin
                // Waiting kiosks are served before a pending close takes effect.
                if (any_req) begin
                    req_ready_nxt = N_KIOSK'(1) << gnt_id;
                    ptr_nxt       = gnt_id + 2'd1;
                    final_nxt     = 1'b0;
                    state_nxt     = ISSUE0;
                end else if (close_req) begin
                    selling_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            ISSUE0: begin
                in_valid_nxt = 1'b1;
                type_nxt     = lat_type;
                if (close_req) begin
                    final_nxt   = 1'b1;
                    selling_nxt = 1'b0;
                end
                state_nxt = ISSUE1;
            end
            ISSUE1: begin
                in_valid_nxt = 1'b1;
                portion_nxt  = lat_portion;
                if (close_req) begin
                    final_nxt   = 1'b1;
                    selling_nxt = 1'b0;
                end
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (k_out_valid_order) begin
                    resp_valid_nxt   = 1'b1;
                    resp_success_nxt = k_success;
                    resp_id_nxt      = lat_id;
                    if (!k_success) begin
                        reject_nxt = sat_inc8(reject_cnt);
                    end
                    cnt_nxt   = '0;
                    state_nxt = final_ord ? TOT_WAIT : OPEN;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nxt     = 1'b1;
                    selling_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = wait_cnt + 1'b1;
                    if (close_req) begin
                        final_nxt   = 1'b1;
                        selling_nxt = 1'b0;
                    end
                end
            end
            TOT_WAIT: begin
                if (k_out_valid_tot) begin
                    tot_valid_nxt = 1'b1;
                    tot_sold_nxt  = k_sold_num;
                    tot_gain_nxt  = k_total_gain;
                    state_nxt     = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nxt     = 1'b1;
                    selling_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                selling_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            close_pend   <= 1'b0;
            final_ord    <= 1'b0;
            rr_ptr       <= '0;
            wait_cnt     <= '0;
            req_ready    <= '0;
            resp_valid   <= 1'b0;
            resp_success <= 1'b0;
            resp_id      <= '0;
            tot_valid    <= 1'b0;
            tot_sold     <= '0;
            tot_gain     <= '0;
            reject_cnt   <= '0;
            err          <= 1'b0;
            k_selling    <= 1'b0;
            k_in_valid   <= 1'b0;
            k_portion    <= 1'b0;
            k_ramen_type <= '0;
        end else begin
            state        <= state_nxt;
            close_pend   <= close_nxt;
            final_ord    <= final_nxt;
            rr_ptr       <= ptr_nxt;
            wait_cnt     <= cnt_nxt;
            req_ready    <= req_ready_nxt;
            resp_valid   <= resp_valid_nxt;
            resp_success <= resp_success_nxt;
            resp_id      <= resp_id_nxt;
            tot_valid    <= tot_valid_nxt;
            tot_sold     <= tot_sold_nxt;
            tot_gain     <= tot_gain_nxt;
            reject_cnt   <= reject_nxt;
            err          <= err_nxt;
            k_selling    <= selling_nxt;
            k_in_valid   <= in_valid_nxt;
            k_portion    <= portion_nxt;
            k_ramen_type <= type_nxt;
        end
    end

    // Order fields are only consumed after a grant loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant_now) begin
            lat_type    <= ramen_type_e'(req_type[{gnt_id, 1'b0} +: 2]);
            lat_portion <= req_portion[gnt_id];
            lat_id      <= gnt_id;
        end
    end

endmodule

// File: tb/tb_ramen_order_arbiter.sv
// Directed bench for ramen_order_arbiter: a cycle table for a single order and session
// edge cases, then hand sequences for rejects, close, totals, timeout, reset and round-robin.
module tb_ramen_order_arbiter;
    import ramen_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              session_start = 1'b0, session_end = 1'b0;
    logic [3:0]        req_valid = 4'b0;
    logic [7:0]        req_type = 8'h10;
    logic [3:0]        req_portion = 4'b0100;
    logic [3:0]        req_ready;
    logic              resp_valid, resp_success;
    logic [1:0]        resp_id;
    logic              tot_valid;
    logic [SOLD_W-1:0] tot_sold;
    logic [GAIN_W-1:0] tot_gain;
    logic [7:0]        reject_cnt;
    logic              err, k_selling, k_in_valid, k_portion;
    logic [1:0]        k_ramen_type;
    logic              k_out_valid_order = 1'b0, k_success = 1'b0, k_out_valid_tot = 1'b0;
    logic [SOLD_W-1:0] k_sold_num = '0;
    logic [GAIN_W-1:0] k_total_gain = '0;

    int checks = 0;
    int failures = 0;

    ramen_order_arbiter #(.N_KIOSK(4), .WAIT_MAX(15)) dut (
        .clk               (clk),
        .rst               (rst),
        .session_start     (session_start),
        .session_end       (session_end),
        .req_valid         (req_valid),
        .req_type          (req_type),
        .req_portion       (req_portion),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_success      (resp_success),
        .resp_id           (resp_id),
        .tot_valid         (tot_valid),
        .tot_sold          (tot_sold),
        .tot_gain          (tot_gain),
        .reject_cnt        (reject_cnt),
        .err               (err),
        .k_selling         (k_selling),
        .k_in_valid        (k_in_valid),
        .k_portion         (k_portion),
        .k_ramen_type      (k_ramen_type),
        .k_out_valid_order (k_out_valid_order),
        .k_success         (k_success),
        .k_out_valid_tot   (k_out_valid_tot),
        .k_sold_num        (k_sold_num),
        .k_total_gain      (k_total_gain)
    );

    always #5 clk = ~clk;

    // {req_ready, k_selling, k_in_valid, k_ramen_type, k_portion, resp_valid, resp_success, resp_id}
    logic [12:0] obs;
    assign obs = {req_ready, k_selling, k_in_valid, k_ramen_type, k_portion,
                  resp_valid, resp_success, resp_id};

    logic any_out;
    assign any_out = |{req_ready, resp_valid, resp_success, resp_id, tot_valid, tot_sold,
                       tot_gain, reject_cnt, err, k_selling, k_in_valid, k_portion, k_ramen_type};

    typedef struct {
        logic        ss;
        logic        se;
        logic [3:0]  rv;
        logic        kov;
        logic        ks;
        logic [12:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic ss, input logic se, input logic [3:0] rv,
                                input logic kov, input logic ks, input logic [12:0] exp,
                                input string name);
        vec_t v;
        v.ss = ss; v.se = se; v.rv = rv; v.kov = kov; v.ks = ks; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            step();
            n++;
        end
    endtask

    task automatic do_order(input logic [3:0] rv, input logic succ, input int id, input string nm);
        logic [3:0] want;
        want = 4'b0001 << id;
        req_valid = rv;
        wait_grant();
        check({nm, "_grant"}, req_ready, want);
        req_valid = 4'b0;
        step();
        step();
        k_out_valid_order = 1'b1;
        k_success = succ;
        step();
        k_out_valid_order = 1'b0;
        k_success = 1'b0;
        check({nm, "_resp"}, {resp_valid, resp_success, resp_id}, {1'b1, succ, 2'(id)});
    endtask

    initial begin
        logic seen;

        tbl[0]  = mk(1, 0, 4'b0000, 0, 0, 13'b0000_1_0_00_0_0_0_00, "t_start");
        tbl[1]  = mk(0, 0, 4'b0100, 0, 0, 13'b0100_1_0_00_0_0_0_00, "t_grant");
        tbl[2]  = mk(0, 0, 4'b0100, 0, 0, 13'b0000_1_1_01_0_0_0_00, "t_beat_type");
        tbl[3]  = mk(0, 0, 4'b0000, 0, 0, 13'b0000_1_1_01_1_0_0_00, "t_beat_portion");
        tbl[4]  = mk(0, 0, 4'b0000, 0, 0, 13'b0000_1_0_01_1_0_0_00, "t_wait");
        tbl[5]  = mk(0, 0, 4'b0000, 1, 1, 13'b0000_1_0_01_1_1_1_10, "t_resp");
        tbl[6]  = mk(0, 0, 4'b0000, 0, 0, 13'b0000_1_0_01_1_0_1_10, "t_resp_pulse");
        tbl[7]  = mk(0, 1, 4'b0000, 0, 0, 13'b0000_0_0_01_1_0_1_10, "t_close");
        tbl[8]  = mk(0, 0, 4'b0000, 0, 0, 13'b0000_0_0_01_1_0_1_10, "t_idle");
        tbl[9]  = mk(0, 1, 4'b0000, 0, 0, 13'b0000_0_0_01_1_0_1_10, "t_end_in_idle");
        tbl[10] = mk(1, 1, 4'b0000, 0, 0, 13'b0000_1_0_01_1_0_1_10, "t_start_and_end");
        tbl[11] = mk(0, 0, 4'b0000, 0, 0, 13'b0000_1_0_01_1_0_1_10, "t_end_was_ignored");
        tbl[12] = mk(0, 1, 4'b0000, 0, 0, 13'b0000_0_0_01_1_0_1_10, "t_close2");

        #2 rst = 1'b1;
        #1;
        check("reset_async", any_out, 1'b0);
        step();
        step();
        check("reset_outputs", any_out, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            session_start     = tbl[i].ss;
            session_end       = tbl[i].se;
            req_valid         = tbl[i].rv;
            k_out_valid_order = tbl[i].kov;
            k_success         = tbl[i].ks;
            step();
            check(tbl[i].name, obs, tbl[i].exp);
        end
        session_start = 0; session_end = 0; req_valid = 0; k_out_valid_order = 0; k_success = 0;

        // Three rejected orders and one accepted one.
        session_start = 1'b1; step(); session_start = 1'b0;
        do_order(4'b0001, 1'b0, 0, "rej0");
        do_order(4'b0010, 1'b0, 1, "rej1");
        do_order(4'b1000, 1'b0, 3, "rej3");
        do_order(4'b0100, 1'b1, 2, "ok2");
        check("reject_cnt3", reject_cnt, 8'd3);

        // Close with no requests: selling drops at once, no totals.
        session_end = 1'b1; step(); session_end = 1'b0;
        check("close_sel_low", k_selling, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | tot_valid;
        end
        check("close_no_tot", seen, 1'b0);
        session_start = 1'b1; step(); session_start = 1'b0;
        check("restart_clean", {k_selling, reject_cnt, err}, {1'b1, 8'd0, 1'b0});

        // Final order: session_end during ISSUE1, then the kitchen reports totals.
        req_valid = 4'b0010;
        wait_grant();
        check("fin_grant", req_ready, 4'b0010);
        req_valid = 4'b0;
        step();
        session_end = 1'b1; step(); session_end = 1'b0;
        check("fin_sel_low", {k_selling, k_in_valid}, 2'b01);
        step();
        k_out_valid_order = 1'b1; k_success = 1'b1; step();
        k_out_valid_order = 1'b0; k_success = 1'b0;
        check("fin_resp", {resp_valid, resp_success, resp_id, tot_valid}, 5'b1_1_01_0);
        step();
        k_out_valid_tot = 1'b1; k_sold_num = 28'h0100100; k_total_gain = 15'd450; step();
        k_out_valid_tot = 1'b0; k_sold_num = '0; k_total_gain = '0;
        check("tot_valid", tot_valid, 1'b1);
        check("tot_sold", tot_sold, 28'h0100100);
        check("tot_gain", tot_gain, 15'd450);
        step();
        check("tot_pulse", {tot_valid, tot_sold, tot_gain}, {1'b0, 28'h0100100, 15'd450});
        req_valid = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | (|req_ready);
        end
        req_valid = 4'b0;
        check("idle_after_tot", {seen, k_selling}, 2'b00);

        // Timeout: kitchen silent in WAIT.
        session_start = 1'b1; step(); session_start = 1'b0;
        req_valid = 4'b0100;
        wait_grant();
        check("to_grant", req_ready, 4'b0100);
        req_valid = 4'b0;
        for (int i = 0; i < 16; i++) step();
        check("to_err_early", {err, k_selling}, 2'b01);
        step();
        check("to_err", {err, k_selling, resp_valid}, 3'b100);
        step();
        check("to_err_sticky", err, 1'b1);
        session_start = 1'b1; step(); session_start = 1'b0;
        check("to_err_cleared", {err, k_selling}, 2'b01);

        // Reset asserted while in ISSUE0.
        req_valid = 4'b0001;
        step();
        check("rm_grant", req_ready, 4'b0001);
        rst = 1'b1;
        #1;
        check("rst_mid", any_out, 1'b0);
        req_valid = 4'b0;
        step();
        rst = 1'b0;
        check("rst_mid_hold", any_out, 1'b0);

        // Fresh session after reset: four continuous requesters rotate 0,1,2,3,0.
        session_start = 1'b1; step(); session_start = 1'b0;
        check("rr_sel", k_selling, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_order(4'b1111, 1'b1, i % 4, $sformatf("rr%0d", i));
        end
        check("rr_no_reject", reject_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
